shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/alu_pkg.sv | 17 +
 rtl/shift_step.sv | 37 +++
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared shift-op and sequencer state encodings
package alu_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
// out_bit is the bit that leaves the word on this step.
module shift_step
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] x,
  input  shift_op_e         op,
  output logic [DATA_W-1:0] y,
  output logic              out_bit
);

  always_comb begin
    y       = x;
    out_bit = 1'b0;
    unique case (op)
      SHIFT_LSL: begin
        y       = {x[DATA_W-2:0], 1'b0};
        out_bit = x[DATA_W-1];
      end
      SHIFT_LSR: begin
        y       = {1'b0, x[DATA_W-1:1]};
        out_bit = x[0];
      end
      SHIFT_ASR: begin
        y       = {x[DATA_W-1], x[DATA_W-1:1]};
        out_bit = x[0];
      end
      SHIFT_ROL: begin
        y       = {x[DATA_W-2:0], x[DATA_W-1]};
        out_bit = x[DATA_W-1];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shifter, one bit per cycle, IDLE/SHIFT/DONE FSM
// Optional carry output enabled by macro SHIFT_SEQUENCER_CARRY_EN.
module shift_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef SHIFT_SEQUENCER_CARRY_EN
  ,
  output logic              carry
`endif
);

  seq_state_e        state_q, state_d;
  shift_op_e         op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] step_y;

`ifdef SHIFT_SEQUENCER_CARRY_EN
  logic carry_q, carry_d;
  logic step_out;
`else
  logic step_out_unused;
`endif

  shift_step #(.DATA_W(DATA_W)) u_step (
    .x       (x_q),
    .op      (op_q),
    .y       (step_y),
`ifdef SHIFT_SEQUENCER_CARRY_EN
    .out_bit (step_out)
`else
    .out_bit (step_out_unused)
`endif
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
`ifdef SHIFT_SEQUENCER_CARRY_EN
    carry_d = carry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = shift_op_e'(op);
          cnt_d   = count;
          x_d     = data_in;
`ifdef SHIFT_SEQUENCER_CARRY_EN
          carry_d = 1'b0;
`endif
          state_d = (count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        x_d   = step_y;
        cnt_d = cnt_q - CNT_W'(1);
`ifdef SHIFT_SEQUENCER_CARRY_EN
        carry_d = step_out;
`endif
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= SHIFT_LSL;
      cnt_q   <= '0;
      x_q     <= '0;
`ifdef SHIFT_SEQUENCER_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
`ifdef SHIFT_SEQUENCER_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = x_q;
`ifdef SHIFT_SEQUENCER_CARRY_EN
  assign carry  = carry_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;
  import alu_pkg::*;

  logic       clk, rst, start;
  logic [1:0] op;
  logic [2:0] count;
  logic [7:0] data_in;
  logic       ready, done;
  logic [7:0] result;
  logic       carry;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    int         lat;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.DATA_W(8), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .count   (count),
    .data_in (data_in),
    .ready   (ready),
    .done    (done),
    .result  (result)
`ifdef SHIFT_SEQUENCER_CARRY_EN
    ,
    .carry   (carry)
`endif
  );

`ifndef SHIFT_SEQUENCER_CARRY_EN
  assign carry = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [8:0] model(input logic [1:0] o, input int n, input logic [7:0] d);
    logic [7:0] x;
    logic       c;
    x = d;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (o)
        2'b00: begin c = x[7]; x = {x[6:0], 1'b0}; end
        2'b01: begin c = x[0]; x = {1'b0, x[7:1]}; end
        2'b10: begin c = x[0]; x = {x[7], x[7:1]}; end
        default: begin c = x[7]; x = {x[6:0], x[7]}; end
      endcase
    end
    return {c, x};
  endfunction

  task automatic push_exp(input logic [1:0] o, input int n, input logic [7:0] d);
    exp_t e;
    logic [8:0] m;
    m     = model(o, n, d);
    e.res = m[7:0];
    e.c   = m[8];
    e.lat = n;
    sb.push_back(e);
  endtask

  // Counts negedges after the accept edge until done; returns cycles-1 as latency.
  task automatic wait_done_and_pop(input string tag, input bit drop_start);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (drop_start) start = 1'b0;
    end while (!done && cyc < 40);
    check({tag, "_done_seen"}, done, 1'b1);
    e = sb.pop_front();
    check({tag, "_latency"}, cyc - 1, e.lat);
    check({tag, "_result"}, result, e.res);
`ifdef SHIFT_SEQUENCER_CARRY_EN
    check({tag, "_carry"}, carry, e.c);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (!ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_ready"}, ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] n, input logic [7:0] d);
    wait_ready(tag);
    start   = 1'b1;
    op      = o;
    count   = n;
    data_in = d;
    push_exp(o, int'(n), d);
    @(posedge clk);
    wait_done_and_pop(tag, 1'b1);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; count = 3'd0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_carry", carry, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op("lsl81", SHIFT_LSL, 3'd3, 8'h81);
    check("lsl81_abs", result, 8'h08);
    run_op("asr90", SHIFT_ASR, 3'd2, 8'h90);
    check("asr90_abs", result, 8'hE4);
    run_op("rol81", SHIFT_ROL, 3'd1, 8'h81);
    check("rol81_abs", result, 8'h03);

    for (int o = 0; o < 4; o++) begin
      run_op($sformatf("cnt0_op%0d", o), 2'(o), 3'd0, 8'h5A);
      check($sformatf("cnt0_op%0d_abs", o), result, 8'h5A);
    end

    for (int i = 0; i < 6; i++)
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)));

    // start held high; operands changed mid-operation must not leak in
    wait_ready("hold");
    start = 1'b1; op = SHIFT_LSR; count = 3'd7; data_in = 8'hFF;
    push_exp(SHIFT_LSR, 7, 8'hFF);
    @(posedge clk);
    #1;
    op = SHIFT_ROL; count = 3'd2; data_in = 8'hC3;
    wait_done_and_pop("hold1", 1'b0);
    check("hold1_abs", result, 8'h01);
    @(negedge clk);
    check("hold_idle_ready", ready, 1'b1);
    check("hold_idle_result", result, 8'h01);
    push_exp(SHIFT_ROL, 2, 8'hC3);
    @(posedge clk);
    wait_done_and_pop("hold2", 1'b1);

    // back-to-back: issue in first IDLE cycle after DONE
    run_op("b2b_a", SHIFT_LSL, 3'd4, 8'h3C);
    @(negedge clk);
    check("b2b_idle_ready", ready, 1'b1);
    check("b2b_held_result", result, 8'hC0);
    run_op("b2b_b", SHIFT_ASR, 3'd3, 8'h80);

    // asynchronous reset mid-SHIFT
    wait_ready("arst");
    start = 1'b1; op = SHIFT_LSL; count = 3'd7; data_in = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", ready, 1'b1);
    check("arst_done", done, 1'b0);
    check("arst_result", result, 8'h00);
    check("arst_carry", carry, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("arst_no_stale_done", seen_done, 1'b0);
    run_op("post_rst", SHIFT_ROL, 3'd5, 8'h96);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
